inst_fetch: RTL

Instruction-fetch sequencer that reads the address driven by the program counter register and issues a handshaked read to instruction memory. It returns the fetched word through a one-entry valid/ready output buffer to the decode stage. It also drives a stall back to the PC-update logic, and handles flush, misaligned addresses and memory timeouts. It sits between the PC register and the instruction memory in the MIPS datapath.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_wait_timer.sv | 43 ++++
 rtl/inst_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   state_e         : FSM states (idle, request outstanding, holding fetched word)
//   ALIGN_MASK      : low address bits that must be zero for a word fetch
//   DEFAULT_TIMEOUT : default number of cycles a request may wait for an ack
package ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ifetch_wait_timer.sv
// Saturating wait counter for an outstanding memory request.
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : zero the counter (wins over enable)
//   enable     : count one waited cycle
//   expired    : the current cycle is the TIMEOUT-th cycle of waiting
module ifetch_wait_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The counter holds the number of cycles already waited, so the cycle in which
  // it reads TIMEOUT-1 is the last one allowed.
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer between the PC register and instruction memory.
// Issues one handshaked read per fetch, buffers the returned word in a one-entry
// valid/ready stage towards decode, and stalls the PC while busy.
//   clk, rst_n          : clock, synchronous active-low reset
//   pc_in, fetch_en     : fetch request from the PC register
//   flush               : discard the in-flight or buffered instruction
//   mem_req, mem_addr   : read request to instruction memory
//   mem_ack, mem_rdata  : memory response
//   instr, instr_pc     : fetched word and its address
//   instr_valid/_ready  : handshake towards decode
//   stall               : PC must hold
//   misalign_err        : one-cycle pulse on a misaligned fetch request
//   timeout_err         : one-cycle pulse when memory never acked
//   fetch_count         : number of instructions delivered (wraps)
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              stall,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic [31:0]       fetch_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              discard_q, discard_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       count_q, count_d;

  logic timer_clear, timer_en, timer_expired;
  logic aligned;

  assign aligned = ((pc_in[1:0] & ALIGN_MASK) == 2'b00);

  ifetch_wait_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    discard_d   = discard_q;
    count_d     = count_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flush here has nothing to cancel, so a simultaneous fetch proceeds.
        if (fetch_en) begin
          if (aligned) begin
            addr_d      = pc_in;
            discard_d   = 1'b0;
            timer_clear = 1'b1;
            state_d     = StReq;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end

      StReq: begin
        if (mem_ack) begin
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = StIdle;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = addr_q;
            state_d    = StHold;
          end
        end else if (timer_expired) begin
          discard_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          // The memory handshake cannot be abandoned; remember to drop the data.
          timer_en = 1'b1;
          if (flush) begin
            discard_d = 1'b1;
          end
        end
      end

      StHold: begin
        if (flush) begin
          state_d = StIdle;
        end else if (instr_ready) begin
          count_d = count_q + 32'd1;
          if (fetch_en && aligned) begin
            addr_d      = pc_in;
            discard_d   = 1'b0;
            timer_clear = 1'b1;
            state_d     = StReq;
          end else begin
            misalign_d = fetch_en;
            state_d    = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      discard_q  <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
    end
  end

  assign mem_req      = (state_q == StReq);
  assign mem_addr     = addr_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = (state_q == StHold);
  assign stall        = (state_q == StReq) || ((state_q == StHold) && !instr_ready);
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;
  assign fetch_count  = count_q;

endmodule
